freq_div_prog: RTL

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

---
 rtl/freq_div_prog.sv | 87 ++++++++
 1 files changed

// File: rtl/freq_div_prog.sv
// Programmable clock divider with an exact 50% duty cycle for both even and odd ratios.
// A new divisor takes effect at a period boundary; while the divider is stopped it applies directly.
module freq_div_prog #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 5
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] div_in,
  input  logic             load_in,
  output logic             clk_out,
  output logic             tick_out,
  output logic [WIDTH-1:0] div_cur_out,
  output logic             pend_out,
  output logic             err_out,
  output logic             running_out
);

  generate
    if (DIV_RESET < 2 || DIV_RESET > (2**WIDTH) - 1) begin : g_bad_div_reset
      $error("freq_div_prog: DIV_RESET out of range 2..2^WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] cnt, cnt_inc, half, pend_val;
  logic             ph_pos, ph_neg;
  logic             load_ok, load_bad, wrap;

  assign load_ok  = load_in && (div_in >= WIDTH'(2));
  assign load_bad = load_in && !load_ok;
  assign cnt_inc  = cnt + WIDTH'(1);
  assign half     = div_cur_out >> 1;
  assign wrap     = running_out && (cnt == div_cur_out - WIDTH'(1));

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      cnt         <= '0;
      ph_pos      <= 1'b0;
      tick_out    <= 1'b0;
      err_out     <= 1'b0;
      pend_out    <= 1'b0;
      pend_val    <= '0;
      running_out <= 1'b0;
      div_cur_out <= WIDTH'(DIV_RESET);
    end else begin
      err_out  <= load_bad;
      tick_out <= 1'b0;
      if (!running_out) begin
        // A value left pending by a stop boundary is applied here, on the first idle cycle.
        if (load_ok)       div_cur_out <= div_in;
        else if (pend_out) div_cur_out <= pend_val;
        pend_out <= 1'b0;
        if (en_in) begin
          running_out <= 1'b1;
          cnt         <= '0;
          ph_pos      <= 1'b1;
          tick_out    <= 1'b1;
        end
      end else if (wrap) begin
        if (pend_out) div_cur_out <= pend_val;
        pend_out <= load_ok;
        if (load_ok) pend_val <= div_in;
        cnt         <= '0;
        ph_pos      <= en_in;
        tick_out    <= en_in;
        running_out <= en_in;
      end else begin
        cnt <= cnt_inc;
        if (cnt_inc == half) ph_pos <= 1'b0;
        if (load_ok) begin
          pend_out <= 1'b1;
          pend_val <= div_in;
        end
      end
    end
  end

  // Half-cycle extension of the high phase, only for odd ratios.
  always_ff @(negedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) ph_neg <= 1'b0;
    else             ph_neg <= ph_pos & div_cur_out[0];
  end

  assign clk_out = ph_pos | ph_neg;

endmodule
